// File: rtl/ofmap_writer_param_1.sv
// Output-feature writer: captures accumulator sums at pixel boundaries, quantizes them
// (shift, optional ReLU, saturate) and streams them into the output feature memory.
module ofmap_writer_param_1 #(
  parameter int DATA_WIDTH        = 16,
  parameter int ACC_WIDTH         = 36,
  parameter int OUT_FEATURE_WIDTH = 32,
  parameter int NUM_ONEMULT       = 1,
  parameter int FRAC_SHIFT        = 8,
  parameter int RELU_EN           = 1,
  parameter int ADDR_WIDTH        = 10,
  parameter int COUNT_BITWIDTH    = 11
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        start,
  input  logic                        accum_sload,
  input  logic signed [ACC_WIDTH-1:0] accum_result,
  output logic                        out_feature_wren,
  output logic [ADDR_WIDTH-1:0]       out_feature_addr,
  output logic [DATA_WIDTH-1:0]       out_feature_data,
  output logic                        busy,
  output logic                        sat_flag,
  output logic                        frame_done
);

  localparam int TOTAL = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH * NUM_ONEMULT;
  localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                        state;
  state_t                        state_next;
  logic [COUNT_BITWIDTH-1:0]     pix_cnt;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic                          capture;
  logic                          last_capture;
  logic                          s1_valid;
  logic signed [ACC_WIDTH-1:0]   s1_value;
  logic [DATA_WIDTH-1:0]         q_data;
  logic                          q_sat;

  assign capture      = accum_sload & enable & (state == RUN);
  assign last_capture = capture & (pix_cnt == COUNT_BITWIDTH'(TOTAL - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FLUSH waits only for stage 1; the stage-2 write in flight completes on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && start) state_next = RUN;
      RUN:     if (last_capture) state_next = FLUSH;
      FLUSH:   if (!s1_valid) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_value <= '0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        pix_cnt  <= pix_cnt + 1'b1;
        s1_value <= accum_result >>> FRAC_SHIFT;
      end
    end
  end

  // Comparisons stay at full accumulator width so oversized sums can never wrap.
  always_comb begin
    q_data = s1_value[DATA_WIDTH-1:0];
    q_sat  = 1'b0;
    if ((RELU_EN != 0) && (s1_value < 0)) begin
      q_data = '0;
    end else if (s1_value > MAX_V) begin
      q_data = MAX_V[DATA_WIDTH-1:0];
      q_sat  = 1'b1;
    end else if (s1_value < MIN_V) begin
      q_data = MIN_V[DATA_WIDTH-1:0];
      q_sat  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_feature_wren <= 1'b0;
      out_feature_addr <= '0;
      out_feature_data <= '0;
      wr_addr          <= '0;
      sat_flag         <= 1'b0;
    end else begin
      out_feature_wren <= s1_valid;
      if (s1_valid) begin
        out_feature_addr <= wr_addr;
        out_feature_data <= q_data;
        wr_addr          <= wr_addr + 1'b1;
        sat_flag         <= sat_flag | q_sat;
      end
    end
  end

  assign busy       = (state == RUN) || (state == FLUSH);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_ofmap_writer_param_1.sv
// Directed bench for ofmap_writer_param_1: a ReLU instance at default size and a
// non-ReLU 2x2 instance share stimulus; a scoreboard tracks every write of the first.
module tb_ofmap_writer_param_1;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               start;
  logic               sload;
  logic signed [35:0] result;

  logic        a_wren, b_wren;
  logic [9:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        a_busy, b_busy, a_sat, b_sat, a_done, b_done;

  int checks   = 0;
  int failures = 0;
  logic [25:0] exp_q[$];

  ofmap_writer_param_1 u_dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .accum_sload(sload), .accum_result(result),
    .out_feature_wren(a_wren), .out_feature_addr(a_addr), .out_feature_data(a_data),
    .busy(a_busy), .sat_flag(a_sat), .frame_done(a_done)
  );

  ofmap_writer_param_1 #(.OUT_FEATURE_WIDTH(2), .RELU_EN(0)) u_small (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .accum_sload(sload), .accum_result(result),
    .out_feature_wren(b_wren), .out_feature_addr(b_addr), .out_feature_data(b_data),
    .busy(b_busy), .sat_flag(b_sat), .frame_done(b_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    reset = 1'b1; enable = 1'b0; start = 1'b0; sload = 1'b0; result = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic go_run();
    enable = 1'b1; start = 1'b1;
    tick();
  endtask

  // One capture on u_dut, checking the two-cycle latency and single-cycle strobe.
  task automatic send_pixel(input logic signed [35:0] val, input logic [9:0] ea, input logic [15:0] ed);
    sload = 1'b1; result = val;
    exp_q.push_back({ea, ed});
    tick();
    sload = 1'b0;
    check("lat_early", 64'(a_wren), 64'd0);
    tick();
    check("lat_wren", 64'(a_wren), 64'd1);
    check("lat_addr", 64'(a_addr), 64'(ea));
    check("lat_data", 64'(a_data), 64'(ed));
    tick();
    check("wren_pulse", 64'(a_wren), 64'd0);
  endtask

  // Scoreboard: every u_dut write must match the next expected {addr, data}.
  always @(negedge clock) begin
    if (!reset && a_wren) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", 64'd1, 64'd0);
      end else begin
        check("sb_word", 64'({a_addr, a_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; sload = 1'b0; result = '0;
    tick();
    check("rst_wren", 64'(a_wren), 64'd0);
    check("rst_addr", 64'(a_addr), 64'd0);
    check("rst_data", 64'(a_data), 64'd0);
    check("rst_flags", 64'({a_busy, a_sat, a_done}), 64'd0);
    do_reset();

    // Sload on the IDLE->RUN edge is not captured.
    enable = 1'b1; start = 1'b1; sload = 1'b1; result = 36'(256 * 99);
    tick();
    sload = 1'b0;
    check("run_busy", 64'(a_busy), 64'd1);
    tick(); tick();
    check("idle_sload_ignored", 64'(a_wren), 64'd0);

    for (int k = 0; k < 4; k++) begin
      send_pixel(36'(256 * k), 10'(k), 16'(k));
      repeat (10) tick();
    end
    check("seq_sat", 64'(a_sat), 64'd0);

    send_pixel(-36'sd512, 10'd4, 16'd0);
    check("relu_sat", 64'(a_sat), 64'd0);
    send_pixel(36'sh7FFFFFFF, 10'd5, 16'h7FFF);
    check("pos_sat", 64'(a_sat), 64'd1);

    // Non-ReLU rails and negative pass-through on u_small.
    do_reset();
    go_run();
    send_pixel(-36'sd1073741824, 10'd0, 16'd0);
    check("neg_rail_data", 64'(b_data), 64'h8000);
    check("neg_rail_sat", 64'(b_sat), 64'd1);
    check("relu_rail_sat", 64'(a_sat), 64'd0);
    repeat (5) tick();
    send_pixel(-36'sd768, 10'd1, 16'd0);
    check("neg_data", 64'(b_data), 64'hFFFD);
    check("neg_addr", 64'(b_addr), 64'd1);

    // Back-to-back frame on the 2x2 instance plus a fifth, ignored sload.
    do_reset();
    go_run();
    for (int i = 0; i < 8; i++) begin
      sload  = (i < 5);
      result = 36'(256 * (5 + i));
      if (i < 5) exp_q.push_back({10'(i), 16'(5 + i)});
      tick();
      check("frm_wren", 64'(b_wren), 64'((i >= 1) && (i <= 4)));
      if ((i >= 1) && (i <= 4)) begin
        check("frm_addr", 64'(b_addr), 64'(i - 1));
        check("frm_data", 64'(b_data), 64'(4 + i));
      end
      check("frm_done", 64'(b_done), 64'(i >= 5));
      check("frm_busy", 64'(b_busy), 64'(i < 5));
    end
    sload = 1'b0;
    tick();

    // In-flight write completes after enable drops; then enable stays low with sloads.
    enable = 1'b1; sload = 1'b1; result = 36'(256 * 10);
    exp_q.push_back({10'd5, 16'd10});
    tick();
    enable = 1'b0; sload = 1'b0; start = 1'b0;
    tick();
    check("inflight_wren", 64'(a_wren), 64'd1);
    check("inflight_addr", 64'(a_addr), 64'd5);
    for (int j = 0; j < 20; j++) begin
      sload  = j[0];
      result = 36'(256 * j);
      tick();
    end
    sload = 1'b0;
    tick(); tick();
    check("hold_addr", 64'(a_addr), 64'd5);
    check("hold_busy", 64'(a_busy), 64'd1);
    enable = 1'b1;
    send_pixel(36'(256 * 20), 10'd6, 16'd20);

    // Reset right after a capture kills the pending write.
    sload = 1'b1; result = 36'(256 * 7);
    tick();
    sload = 1'b0; reset = 1'b1;
    #1;
    check("rst_mid_wren", 64'(a_wren), 64'd0);
    tick(); tick();
    check("rst_mid_outs", 64'({a_wren, a_addr, a_data, a_busy, a_sat, a_done}), 64'd0);
    reset = 1'b0; enable = 1'b0; start = 1'b0;
    tick();
    go_run();
    send_pixel(36'(256 * 3), 10'd0, 16'd3);

    repeat (4) tick();
    check("sb_left", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ofmap_writer_param_1.md
Name: ofmap_writer_param_1

Overview:
- Consumer end of the convolution control/accumulator path.
- Captures each finished accumulator sum at the pixel boundary marked by accum_sload.
- Quantizes the sum (arithmetic shift, optional ReLU, saturate) and writes it sequentially into the output feature M9K.
- Raises frame_done after the last pixel of the output map has been written.

Parameters:
- DATA_WIDTH, 16, output feature word width (signed).
- ACC_WIDTH, 36, accumulator result width (signed).
- OUT_FEATURE_WIDTH, 32, output map side length.
- NUM_ONEMULT, 1, output maps produced per multiplier.
- FRAC_SHIFT, 8, arithmetic right shift applied to the accumulator.
- RELU_EN, 1, 1 = clamp negative results to 0 before saturation.
- ADDR_WIDTH, 10, output memory address width.
- COUNT_BITWIDTH, 11, pixel counter width; must hold OUT_FEATURE_WIDTH*OUT_FEATURE_WIDTH*NUM_ONEMULT.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- enable, input, 1, global enable; low freezes capture.
- start, input, 1, level from the conv control; high means accumulator results are meaningful.
- accum_sload, input, 1, pixel-boundary strobe; accum_result is final on this cycle.
- accum_result, input, ACC_WIDTH, signed accumulator sum.
- out_feature_wren, output, 1, write strobe to the output M9K.
- out_feature_addr, output, ADDR_WIDTH, write address.
- out_feature_data, output, DATA_WIDTH, quantized write data.
- busy, output, 1, high in RUN or FLUSH.
- sat_flag, output, 1, sticky: at least one result saturated.
- frame_done, output, 1, sticky: all pixels written.

Behaviour:
- One clock domain. Reset is asynchronous, active-high.
- Reset values: all outputs 0, pixel counter 0, state IDLE, pipeline valids 0.
- Total pixel count TOTAL = OUT_FEATURE_WIDTH*OUT_FEATURE_WIDTH*NUM_ONEMULT.
- State machine:
  - IDLE -> RUN when enable & start.
  - RUN -> FLUSH on the capture of pixel TOTAL-1.
  - FLUSH -> DONE when both pipeline stages are empty.
  - DONE is held until reset.
- Capture condition: accum_sload & enable & state==RUN. accum_sload in IDLE, FLUSH or DONE is ignored.
  - The accum_sload that causes IDLE->RUN in the same cycle is not captured; the first capture happens in RUN.
- Pipeline: two stages, fully pipelined, and accepts a capture every cycle.
  - Stage 1 (cycle N+1): register accum_result >>> FRAC_SHIFT (sign-preserving).
  - Stage 2 (cycle N+2):
    - If RELU_EN and value < 0, the value becomes 0.
    - Else saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - Assert out_feature_wren for one cycle with data and address.
- Capture-to-wren latency is exactly 2 cycles.
- Address:
  - First write goes to address 0.
  - Address increments by 1 after each write.
  - Address equals the pixel index mod 2^ADDR_WIDTH (wrap permitted only if ADDR_WIDTH is undersized).
- sat_flag is set on the stage-2 cycle where clamping to a rail occurs. The ReLU zero clamp does not count.
- frame_done rises the cycle after the final wren. busy is low in the same cycle frame_done rises.
- enable low mid-frame:
  - No new captures; counter and state are held.
  - In-flight pipeline entries still complete their writes.
- start dropping mid-RUN has no effect; only enable gates.
- Reset mid-frame clears everything immediately, including a pending wren; no partial write is issued after reset.
- Accumulator values wider than the sum of DATA_WIDTH and FRAC_SHIFT are handled by the saturation; no wrap-around of data is ever allowed.

Test Plan:
- Reset, then enable=1, start=1; accum_sload every 13 cycles with accum_result = 256*k for pixel k=0..3 (FRAC_SHIFT=8) -> wren 2 cycles after each sload, addr 0,1,2,3, data 0,1,2,3, sat_flag=0.
- RELU_EN=1: accum_result = -512 -> data 0, sat_flag stays 0. Separately, accum_result = 0x7FFFFFFF -> data 0x7FFF, sat_flag=1.
- RELU_EN=0: accum_result = -(2^30) -> data 0x8000, sat_flag=1. accum_result = -768 -> data 0xFFFD.
- OUT_FEATURE_WIDTH=2, NUM_ONEMULT=1: 4 captures on back-to-back sloads (cycles 10..13) -> wren on cycles 12..15, frame_done=1 on cycle 16, a fifth sload produces no wren.
- Frame in progress: enable low for 20 cycles with sloads continuing -> no captures, addr held. After enable returns high, the next capture uses the next address with no gap or duplicate.
- Assert reset one cycle after a capture -> no wren follows, all outputs 0. A rerun starts at addr 0.
